// File: rtl/spi_flash_resp.sv
// rtl/spi_flash_resp.sv - oversampled SPI NOR flash responder backed by an internal byte array
// Optional quad output read (opcode 0x6B) is built when FLASH_RESP_QUAD_READ_EN is defined.

module spi_flash_resp #(
    parameter int DEPTH  = 4096,
    parameter int SECTOR = 4096,
    parameter int PAGE   = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic spi_clk_i,
    input  logic spi_ss_i,
    input  logic spi_dq0_i,
    output logic spi_dq0_o,
    output logic spi_dq0_oe_o,
    output logic spi_dq1_o,
    output logic spi_dq1_oe_o,
    output logic spi_dq2_o,
    output logic spi_dq2_oe_o,
    output logic spi_dq3_o,
    output logic spi_dq3_oe_o,
    output logic busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE - 1);
    localparam logic [AW-1:0] SECT_MASK = AW'(SECTOR - 1);
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_ERASE = 8'h20;
`ifdef FLASH_RESP_QUAD_READ_EN
    localparam logic [7:0] OP_QREAD = 8'h6B;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_PROG, S_STAT, S_IGNORE
    } state_t;

    // Deferred actions that only take effect when the frame closes.
    typedef enum logic [2:0] {
        A_NONE, A_WREN, A_WRDI, A_PROG, A_ERASE
    } act_t;

    logic [7:0]    mem [DEPTH];

    logic [1:0]    sclk_sync, ss_sync, mosi_sync;
    logic          sclk_q;
    logic          sclk, ss, mosi, rise, fall;

    state_t        state;
    act_t          pend;
    logic [7:0]    op;
    logic [4:0]    cnt;
    logic [23:0]   shreg;
    logic [AW-1:0] addr;
    logic [7:0]    tx_byte;
    logic          fetch_pend;
    logic          wel, wip;
    logic [AW-1:0] erase_base, erase_cnt;
    logic          dq1_q, dq1_oe_q;

    logic [7:0]    opc;
    logic [23:0]   addr_full;
    logic [7:0]    status;
    logic [AW-1:0] page_next;
    logic          prog_we;
    logic          unused_addr;

    assign sclk      = sclk_sync[1];
    assign ss        = ss_sync[1];
    assign mosi      = mosi_sync[1];
    assign rise      = sclk & ~sclk_q;
    assign fall      = ~sclk & sclk_q;

    assign opc       = {shreg[6:0], mosi};
    assign addr_full = {shreg[22:0], mosi};
    assign status    = {6'b0, wel, wip};
    assign page_next = (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
    assign prog_we   = !ss && (state == S_PROG) && rise && (cnt == 5'd7) && wel;
    assign unused_addr = ^{shreg[23], addr_full[23:AW]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= 2'b00;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk_i};
            ss_sync   <= {ss_sync[0], spi_ss_i};
            mosi_sync <= {mosi_sync[0], spi_dq0_i};
            sclk_q    <= sclk;
        end
    end

    // Array is never reset: erase and program are the only ways to change it.
    always_ff @(posedge clk_i) begin
        if (wip)
            mem[erase_base | erase_cnt] <= 8'hFF;
        else if (prog_we)
            mem[addr] <= opc;
    end

`ifdef FLASH_RESP_QUAD_READ_EN
    logic dq0_q, dq2_q, dq3_q, qoe_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            pend       <= A_NONE;
            op         <= 8'h00;
            cnt        <= 5'd0;
            shreg      <= 24'd0;
            addr       <= '0;
            tx_byte    <= 8'h00;
            fetch_pend <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            erase_base <= '0;
            erase_cnt  <= '0;
            dq1_q      <= 1'b0;
            dq1_oe_q   <= 1'b0;
`ifdef FLASH_RESP_QUAD_READ_EN
            dq0_q      <= 1'b0;
            dq2_q      <= 1'b0;
            dq3_q      <= 1'b0;
            qoe_q      <= 1'b0;
`endif
        end else begin
            if (wip) begin
                erase_cnt <= erase_cnt + AW'(1);
                if (erase_cnt == SECT_MASK) begin
                    wip <= 1'b0;
                    wel <= 1'b0;
                end
            end

            if (fetch_pend) begin
                fetch_pend <= 1'b0;
                tx_byte    <= (state == S_STAT) ? status : mem[addr];
            end

            if (ss) begin
                state      <= S_IDLE;
                cnt        <= 5'd0;
                fetch_pend <= 1'b0;
                pend       <= A_NONE;
                dq1_q      <= 1'b0;
                dq1_oe_q   <= 1'b0;
`ifdef FLASH_RESP_QUAD_READ_EN
                dq0_q      <= 1'b0;
                dq2_q      <= 1'b0;
                dq3_q      <= 1'b0;
                qoe_q      <= 1'b0;
`endif
                case (pend)
                    A_WREN:  wel <= 1'b1;
                    A_WRDI:  wel <= 1'b0;
                    A_PROG:  wel <= 1'b0;
                    A_ERASE: if (wel) begin
                        wip        <= 1'b1;
                        erase_base <= addr & ~SECT_MASK;
                        erase_cnt  <= '0;
                    end
                    default: ;
                endcase
            end else begin
                case (state)
                    S_IDLE, S_CMD: begin
                        state <= S_CMD;
                        if (rise) begin
                            shreg <= {shreg[22:0], mosi};
                            cnt   <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt <= 5'd0;
                                if (wip && opc != OP_RDSR) begin
                                    state <= S_IGNORE;
                                end else begin
                                    case (opc)
                                        OP_WREN: begin pend <= A_WREN; state <= S_IGNORE; end
                                        OP_WRDI: begin pend <= A_WRDI; state <= S_IGNORE; end
                                        OP_RDSR: begin tx_byte <= status; state <= S_STAT; end
                                        OP_READ, OP_ERASE: begin op <= opc; state <= S_ADDR; end
                                        OP_PP: begin op <= opc; pend <= A_PROG; state <= S_ADDR; end
`ifdef FLASH_RESP_QUAD_READ_EN
                                        OP_QREAD: begin op <= opc; state <= S_ADDR; end
`endif
                                        default: state <= S_IGNORE;
                                    endcase
                                end
                            end
                        end
                    end

                    S_ADDR: if (rise) begin
                        shreg <= {shreg[22:0], mosi};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd23) begin
                            cnt  <= 5'd0;
                            addr <= addr_full[AW-1:0];
                            case (op)
                                OP_READ:  begin state <= S_READ; fetch_pend <= 1'b1; end
                                OP_PP:    state <= S_PROG;
                                OP_ERASE: begin pend <= A_ERASE; state <= S_IGNORE; end
`ifdef FLASH_RESP_QUAD_READ_EN
                                OP_QREAD: begin state <= S_DUMMY; fetch_pend <= 1'b1; end
`endif
                                default:  state <= S_IGNORE;
                            endcase
                        end
                    end

                    S_DUMMY: if (rise) begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt   <= 5'd0;
                            state <= S_READ;
                        end
                    end

                    // Bits leave on the falling edge so they are stable at the controller's rise.
                    S_READ, S_STAT: if (fall) begin
                        cnt <= cnt + 5'd1;
`ifdef FLASH_RESP_QUAD_READ_EN
                        if (state == S_READ && op == OP_QREAD) begin
                            {dq3_q, dq2_q, dq1_q, dq0_q} <= tx_byte[7:4];
                            tx_byte  <= {tx_byte[3:0], 4'b0};
                            dq1_oe_q <= 1'b1;
                            qoe_q    <= 1'b1;
                            if (cnt == 5'd1) begin
                                cnt        <= 5'd0;
                                addr       <= addr + AW'(1);
                                fetch_pend <= 1'b1;
                            end
                        end else
`endif
                        begin
                            dq1_q    <= tx_byte[7];
                            dq1_oe_q <= 1'b1;
                            tx_byte  <= {tx_byte[6:0], 1'b0};
                            if (cnt == 5'd7) begin
                                cnt        <= 5'd0;
                                addr       <= addr + AW'(1);
                                fetch_pend <= 1'b1;
                            end
                        end
                    end

                    S_PROG: if (rise) begin
                        shreg <= {shreg[22:0], mosi};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt  <= 5'd0;
                            addr <= page_next;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign spi_dq1_o    = dq1_q;
    assign spi_dq1_oe_o = dq1_oe_q;
    assign busy_o       = wip;
`ifdef FLASH_RESP_QUAD_READ_EN
    assign spi_dq0_o    = dq0_q;
    assign spi_dq0_oe_o = qoe_q;
    assign spi_dq2_o    = dq2_q;
    assign spi_dq2_oe_o = qoe_q;
    assign spi_dq3_o    = dq3_q;
    assign spi_dq3_oe_o = qoe_q;
`else
    assign spi_dq0_o    = 1'b0;
    assign spi_dq0_oe_o = 1'b0;
    assign spi_dq2_o    = 1'b0;
    assign spi_dq2_oe_o = 1'b0;
    assign spi_dq3_o    = 1'b0;
    assign spi_dq3_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_resp.sv
// tb/tb_spi_flash_resp.sv - self-checking bench for spi_flash_resp with a byte-array flash model

module tb_spi_flash_resp;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic spi_clk = 1'b0;
    logic spi_ss = 1'b1;
    logic spi_dq0 = 1'b0;
    logic dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe, busy_o;

    int checks = 0;
    int failures = 0;
    int busy_cycles = 0;

    logic [7:0] model_mem [4096];
    logic       model_wel = 1'b0;
    logic [7:0] rbuf [16];
    logic [7:0] wbuf [16];

    spi_flash_resp dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .spi_clk_i    (spi_clk),
        .spi_ss_i     (spi_ss),
        .spi_dq0_i    (spi_dq0),
        .spi_dq0_o    (dq0_o),
        .spi_dq0_oe_o (dq0_oe),
        .spi_dq1_o    (dq1_o),
        .spi_dq1_oe_o (dq1_oe),
        .spi_dq2_o    (dq2_o),
        .spi_dq2_oe_o (dq2_oe),
        .spi_dq3_o    (dq3_o),
        .spi_dq3_oe_o (dq3_oe),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (busy_o) busy_cycles++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [3:0] oe_any);
        rx = 8'h00;
        oe_any = 4'h0;
        for (int i = 7; i >= 0; i--) begin
            spi_dq0 = tx[i];
            #50;
            rx[i] = dq1_o;
            oe_any |= {dq3_oe, dq2_oe, dq1_oe, dq0_oe};
            spi_clk = 1'b1;
            #50;
            spi_clk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] rx;
        logic [3:0] oe;
        xfer(b, rx, oe);
    endtask

    task automatic frame_begin();
        spi_ss = 1'b0;
        #50;
    endtask

    task automatic frame_end();
        #50;
        spi_ss = 1'b1;
        #300;
    endtask

    task automatic send_addr(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic cmd1(input logic [7:0] op);
        frame_begin();
        send(op);
        frame_end();
        if (op == 8'h06) model_wel = 1'b1;
        if (op == 8'h04) model_wel = 1'b0;
    endtask

    task automatic rdsr(output logic [7:0] s, output logic [3:0] oe);
        frame_begin();
        send(8'h05);
        xfer(8'h00, s, oe);
        frame_end();
    endtask

    task automatic do_read(input logic [23:0] a, input int n, output logic [3:0] oe_or);
        logic [3:0] oe;
        oe_or = 4'h0;
        frame_begin();
        send(8'h03);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, rbuf[i], oe);
            oe_or |= oe;
        end
        frame_end();
    endtask

    // Model: program lands inside the 256-byte page of the 4 KiB-truncated address.
    task automatic do_pp(input logic [23:0] a, input int n);
        int idx, base;
        frame_begin();
        send(8'h02);
        send_addr(a);
        for (int i = 0; i < n; i++) send(wbuf[i]);
        frame_end();
        idx = int'(a) % 4096;
        base = idx - (idx % 256);
        if (model_wel)
            for (int i = 0; i < n; i++) model_mem[base + ((idx % 256 + i) % 256)] = wbuf[i];
        model_wel = 1'b0;
    endtask

    function automatic logic [7:0] model_at(input logic [23:0] a, input int i);
        return model_mem[(int'(a) + i) % 4096];
    endfunction

    task automatic test_reset();
        logic [7:0] s;
        logic [3:0] oe;
        rst_ni = 1'b0;
        #103;
        checks++;
        if ({dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe, busy_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs_in_reset: actual=%b required=0", {dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe, busy_o});
        end
        rst_ni = 1'b1;
        #100;
        checks++;
        if ({dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe, busy_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs_idle: actual=%b required=0", {dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe, busy_o});
        end
        rdsr(s, oe);
        checks++;
        if (s !== 8'h00) begin failures++; $display("FAIL reset_rdsr: actual=%h required=00", s); end
        checks++;
        if (oe !== 4'b0010) begin failures++; $display("FAIL reset_rdsr_oe: actual=%b required=0010", oe); end
    endtask

    task automatic test_wel();
        logic [7:0] s;
        logic [3:0] oe;
        cmd1(8'h06);
        rdsr(s, oe);
        checks++;
        if (s !== {6'b0, model_wel, 1'b0}) begin failures++; $display("FAIL wren_status: actual=%h required=%h", s, {6'b0, model_wel, 1'b0}); end
        cmd1(8'h04);
        rdsr(s, oe);
        checks++;
        if (s !== {6'b0, model_wel, 1'b0}) begin failures++; $display("FAIL wrdi_status: actual=%h required=%h", s, {6'b0, model_wel, 1'b0}); end
    endtask

    task automatic test_erase();
        logic [7:0] s;
        logic [3:0] oe;
        int base, polls;
        cmd1(8'h06);
        base = busy_cycles;
        frame_begin();
        send(8'h20);
        send_addr(24'h000000);
        frame_end();
        frame_begin();
        send(8'h05);
        xfer(8'h00, s, oe);
        checks++;
        if (s !== 8'h03) begin failures++; $display("FAIL erase_first_status: actual=%h required=03", s); end
        polls = 0;
        while (s !== 8'h00 && polls < 200) begin
            xfer(8'h00, s, oe);
            polls++;
        end
        frame_end();
        checks++;
        if (s !== 8'h00) begin failures++; $display("FAIL erase_done: actual=%h required=00 within 200 polls", s); end
        checks++;
        if (busy_cycles - base !== 4096) begin failures++; $display("FAIL erase_duration: actual=%0d required=4096", busy_cycles - base); end
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'hFF;
        model_wel = 1'b0;
        do_read(24'h000010, 2, oe);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rbuf[i] !== 8'hFF) begin failures++; $display("FAIL erase_read[%0d]: actual=%h required=FF", i, rbuf[i]); end
        end
    endtask

    task automatic test_page_wrap();
        logic [7:0] s;
        logic [3:0] oe;
        logic [7:0] exp_fe [2];
        exp_fe[0] = 8'hA5;
        exp_fe[1] = 8'h5A;
        cmd1(8'h06);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
        do_pp(24'h0000FE, 3);
        do_read(24'h0000FE, 2, oe);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rbuf[i] !== exp_fe[i]) begin failures++; $display("FAIL page_read[%0d]: actual=%h required=%h", i, rbuf[i], exp_fe[i]); end
        end
        do_read(24'h000000, 1, oe);
        checks++;
        if (rbuf[0] !== 8'hC3) begin failures++; $display("FAIL page_wrap_byte: actual=%h required=C3", rbuf[0]); end
        rdsr(s, oe);
        checks++;
        if (s !== 8'h00) begin failures++; $display("FAIL pp_clears_wel: actual=%h required=00", s); end
    endtask

    task automatic test_no_wren();
        logic [3:0] oe;
        wbuf[0] = 8'h12;
        do_pp(24'h000020, 1);
        do_read(24'h000020, 1, oe);
        checks++;
        if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL pp_without_wren: actual=%h required=FF", rbuf[0]); end
    endtask

    task automatic test_depth_wrap();
        logic [3:0] oe;
        cmd1(8'h06);
        wbuf[0] = 8'h77;
        do_pp(24'h000FFF, 1);
        cmd1(8'h06);
        wbuf[0] = 8'h88;
        do_pp(24'h000000, 1);
        do_read(24'h000FFF, 2, oe);
        checks++;
        if (rbuf[0] !== 8'h77) begin failures++; $display("FAIL depth_wrap_last: actual=%h required=77", rbuf[0]); end
        checks++;
        if (rbuf[1] !== 8'h88) begin failures++; $display("FAIL depth_wrap_first: actual=%h required=88", rbuf[1]); end
        frame_begin();
        send(8'h9F);
        oe = 4'h0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] rx;
            logic [3:0] o;
            xfer(8'h00, rx, o);
            oe |= o;
        end
        frame_end();
        checks++;
        if (oe !== 4'h0) begin failures++; $display("FAIL bad_opcode_oe: actual=%b required=0000", oe); end
    endtask

    task automatic test_quad();
        logic [3:0] nib, oe;
        logic [7:0] b;
        frame_begin();
        send(8'h6B);
        send_addr(24'h0000FE);
`ifdef FLASH_RESP_QUAD_READ_EN
        send(8'h00);
        for (int k = 0; k < 4; k++) begin
            #50;
            nib = {dq3_o, dq2_o, dq1_o, dq0_o};
            oe = {dq3_oe, dq2_oe, dq1_oe, dq0_oe};
            spi_clk = 1'b1;
            #50;
            spi_clk = 1'b0;
            b = model_at(24'h0000FE, k / 2);
            checks++;
            if (nib !== ((k % 2 == 0) ? b[7:4] : b[3:0])) begin
                failures++;
                $display("FAIL quad_nibble[%0d]: actual=%h required=%h", k, nib, (k % 2 == 0) ? b[7:4] : b[3:0]);
            end
            checks++;
            if (oe !== 4'hF) begin failures++; $display("FAIL quad_oe[%0d]: actual=%b required=1111", k, oe); end
        end
        frame_end();
`else
        oe = 4'h0;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] o;
            xfer(8'h00, b, o);
            oe |= o;
        end
        nib = oe;
        frame_end();
        checks++;
        if (nib !== 4'h0) begin failures++; $display("FAIL quad_disabled_oe: actual=%b required=0000", nib); end
`endif
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [3:0] oe;
        int n;
        for (int it = 0; it < 20; it++) begin
            a = 24'($urandom);
            n = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) != 0) cmd1(8'h06);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_pp(a, n);
            end else begin
                do_read(a, n, oe);
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (rbuf[i] !== model_at(a, i)) begin
                        failures++;
                        $display("FAIL random_read addr=%h byte %0d: actual=%h required=%h", a, i, rbuf[i], model_at(a, i));
                    end
                end
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_wel();
        test_erase();
        test_page_wrap();
        test_no_wren();
        test_depth_wrap();
        test_quad();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
